// File: rtl/rv32_load_store_unit.sv
// RV32 load/store unit: single-outstanding initiator on the data memory port.
// Checks alignment, replicates store data across lanes and formats load data.
package rv32_lsu_pkg;

   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LH  = 4'd2,
      MEM_LW  = 4'd3,
      MEM_LBU = 4'd4,
      MEM_LHU = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_op_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      mem_op_t     op;
   } memory_request_t;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } memory_response_t;

endpackage

module rv32_load_store_unit
   import rv32_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  mem_op_t          req_op,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [4:0]       req_rd,
   output memory_request_t  mem_request,
   input  memory_response_t mem_response,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [4:0]       resp_rd,
   output logic [1:0]       resp_fault
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] FAULT_OK       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

   function automatic logic is_access(input mem_op_t op);
      case (op)
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
         MEM_SB, MEM_SH, MEM_SW: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic is_load(input mem_op_t op);
      case (op)
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lane);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: return lane[0];
         MEM_LW, MEM_SW:          return (lane != 2'b00);
         default:                 return 1'b0;
      endcase
   endfunction

   // Replicate store data so every byte lane carries its write data.
   function automatic logic [31:0] store_lanes(input mem_op_t op, input logic [31:0] w);
      case (op)
         MEM_SB:  return {4{w[7:0]}};
         MEM_SH:  return {2{w[15:0]}};
         MEM_SW:  return w;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] load_format(input mem_op_t op, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (op)
         MEM_LB:  return {{24{b[7]}}, b};
         MEM_LBU: return {24'd0, b};
         MEM_LH:  return {{16{h[15]}}, h};
         MEM_LHU: return {16'd0, h};
         MEM_LW:  return word;
         default: return 32'd0;
      endcase
   endfunction

   state_t          state_r, state_s;
   mem_op_t         op_r, op_s;
   logic [1:0]      lane_r, lane_s;
   logic [4:0]      rd_r, rd_s;
   logic [7:0]      cnt_r, cnt_s;
   logic            req_ready_r, req_ready_s;
   logic            resp_valid_r, resp_valid_s;
   logic [31:0]     resp_data_r, resp_data_s;
   logic [4:0]      resp_rd_r, resp_rd_s;
   logic [1:0]      resp_fault_r, resp_fault_s;
   memory_request_t mem_request_r, mem_request_s;

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= IDLE;
         op_r          <= MEM_NOP;
         lane_r        <= 2'd0;
         rd_r          <= 5'd0;
         cnt_r         <= 8'd0;
         req_ready_r   <= 1'b1;
         resp_valid_r  <= 1'b0;
         resp_data_r   <= 32'd0;
         resp_rd_r     <= 5'd0;
         resp_fault_r  <= FAULT_OK;
         mem_request_r <= '{addr: 32'd0, data: 32'd0, op: MEM_NOP};
      end else begin
         state_r       <= state_s;
         op_r          <= op_s;
         lane_r        <= lane_s;
         rd_r          <= rd_s;
         cnt_r         <= cnt_s;
         req_ready_r   <= req_ready_s;
         resp_valid_r  <= resp_valid_s;
         resp_data_r   <= resp_data_s;
         resp_rd_r     <= resp_rd_s;
         resp_fault_r  <= resp_fault_s;
         mem_request_r <= mem_request_s;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_s       = state_r;
      op_s          = op_r;
      lane_s        = lane_r;
      rd_s          = rd_r;
      cnt_s         = cnt_r;
      req_ready_s   = req_ready_r;
      resp_valid_s  = resp_valid_r;
      resp_data_s   = resp_data_r;
      resp_rd_s     = resp_rd_r;
      resp_fault_s  = resp_fault_r;
      mem_request_s = mem_request_r;

      case (state_r)
         IDLE: begin
            if (req_valid && req_ready_r) begin
               lane_s = req_addr[1:0];
               rd_s   = req_rd;
               if (!is_access(req_op)) begin
                  op_s = MEM_NOP;
               end else if (is_misaligned(req_op, req_addr[1:0])) begin
                  op_s         = req_op;
                  state_s      = RESP;
                  req_ready_s  = 1'b0;
                  resp_valid_s = 1'b1;
                  resp_data_s  = 32'd0;
                  resp_rd_s    = req_rd;
                  resp_fault_s = FAULT_MISALIGN;
               end else begin
                  op_s               = req_op;
                  state_s            = REQ;
                  req_ready_s        = 1'b0;
                  mem_request_s.op   = req_op;
                  mem_request_s.addr = req_addr;
                  mem_request_s.data = store_lanes(req_op, req_wdata);
               end
            end else begin
               req_ready_s = 1'b1;
            end
         end
         REQ: begin
            mem_request_s.op = MEM_NOP;
            cnt_s            = 8'd0;
            state_s          = WAIT;
         end
         WAIT: begin
            // Ready wins over a simultaneous timeout.
            if (mem_response.ready) begin
               state_s      = RESP;
               resp_valid_s = 1'b1;
               resp_rd_s    = rd_r;
               resp_fault_s = FAULT_OK;
               resp_data_s  = is_load(op_r) ? load_format(op_r, lane_r, mem_response.data) : 32'd0;
            end else if (cnt_r >= TIMEOUT_LAST) begin
               state_s      = RESP;
               resp_valid_s = 1'b1;
               resp_rd_s    = rd_r;
               resp_fault_s = FAULT_TIMEOUT;
               resp_data_s  = 32'd0;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_s      = IDLE;
               req_ready_s  = 1'b1;
               resp_valid_s = 1'b0;
               resp_data_s  = 32'd0;
               resp_fault_s = FAULT_OK;
            end else begin
               req_ready_s = 1'b0;
            end
         end
         default: begin
            state_s          = IDLE;
            req_ready_s      = 1'b1;
            resp_valid_s     = 1'b0;
            resp_data_s      = 32'd0;
            resp_fault_s     = FAULT_OK;
            mem_request_s.op = MEM_NOP;
         end
      endcase
   end

   assign req_ready   = req_ready_r;
   assign resp_valid  = resp_valid_r;
   assign resp_data   = resp_data_r;
   assign resp_rd     = resp_rd_r;
   assign resp_fault  = resp_fault_r;
   assign mem_request = mem_request_r;

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Directed bench for rv32_load_store_unit with a one-cycle-latency memory model.
module tb_rv32_load_store_unit;
   import rv32_lsu_pkg::*;

   logic             clk = 1'b0;
   logic             resetn;
   logic             req_valid;
   logic             req_ready;
   mem_op_t          req_op;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [4:0]       req_rd;
   memory_request_t  mem_request;
   memory_response_t mem_response;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_data;
   logic [4:0]       resp_rd;
   logic [1:0]       resp_fault;

   logic             mem_en;
   logic [31:0]      mem [0:255];
   int               n_cmp = 0;
   int               n_err = 0;

   rv32_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .mem_request  (mem_request),
      .mem_response (mem_response),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_rd      (resp_rd),
      .resp_fault   (resp_fault)
   );

   always #5 clk = ~clk;

   // Memory: answers any issued op in the following cycle.
   always @(posedge clk) begin
      if (!resetn) begin
         mem_response <= '0;
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem[8'h40] <= 32'h8899AABB;
      end else if (mem_en && mem_request.op != MEM_NOP) begin
         mem_response.ready <= 1'b1;
         mem_response.data  <= mem[mem_request.addr[9:2]];
         case (mem_request.op)
            MEM_SB: mem[mem_request.addr[9:2]][{mem_request.addr[1:0], 3'b000} +: 8] <=
                       mem_request.data[{mem_request.addr[1:0], 3'b000} +: 8];
            MEM_SH: mem[mem_request.addr[9:2]][{mem_request.addr[1], 4'b0000} +: 16] <=
                       mem_request.data[{mem_request.addr[1], 4'b0000} +: 16];
            MEM_SW: mem[mem_request.addr[9:2]] <= mem_request.data;
            default: ;
         endcase
      end else begin
         mem_response.ready <= 1'b0;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge while req_ready=1; returns #1 into the cycle after acceptance.
   task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] w,
                        input logic [4:0] rd);
      req_op    = op;
      req_addr  = a;
      req_wdata = w;
      req_rd    = rd;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = MEM_NOP;
   endtask

   task automatic wait_resp(output int cyc);
      cyc = 0;
      while (!resp_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic access(input string tag, input mem_op_t op, input logic [31:0] a,
                         input logic [31:0] w, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic [1:0] exp_fault,
                         input int exp_lat);
      int c;
      issue(op, a, w, rd);
      if (exp_fault == 2'b00) begin
         check_value({tag, ".req_op"}, 32'(mem_request.op), 32'(op));
         check_value({tag, ".req_addr"}, mem_request.addr, a);
      end else begin
         check_value({tag, ".no_op"}, 32'(mem_request.op), 32'(MEM_NOP));
      end
      wait_resp(c);
      check_value({tag, ".latency"}, 32'(c), 32'(exp_lat));
      check_value({tag, ".data"}, resp_data, exp_data);
      check_value({tag, ".fault"}, 32'(resp_fault), 32'(exp_fault));
      check_value({tag, ".rd"}, 32'(resp_rd), 32'(rd));
      @(posedge clk);
      #1;
      check_value({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
      check_value({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int c;
      resetn     = 1'b0;
      req_valid  = 1'b0;
      req_op     = MEM_NOP;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_rd     = 5'd0;
      resp_ready = 1'b1;
      mem_en     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_value("rst.req_ready", 32'(req_ready), 32'd1);
      check_value("rst.resp_valid", 32'(resp_valid), 32'd0);
      check_value("rst.resp_data", resp_data, 32'd0);
      check_value("rst.resp_fault", 32'(resp_fault), 32'd0);
      check_value("rst.mem_op", 32'(mem_request.op), 32'(MEM_NOP));
      resetn = 1'b1;
      @(posedge clk);
      #1;

      access("lw100",  MEM_LW,  32'h100, 32'd0, 5'd1, 32'h8899AABB, 2'b00, 2);
      access("lb102",  MEM_LB,  32'h102, 32'd0, 5'd2, 32'hFFFFFF99, 2'b00, 2);
      access("lbu102", MEM_LBU, 32'h102, 32'd0, 5'd3, 32'h00000099, 2'b00, 2);
      access("lh102",  MEM_LH,  32'h102, 32'd0, 5'd4, 32'hFFFF8899, 2'b00, 2);
      access("lhu100", MEM_LHU, 32'h100, 32'd0, 5'd5, 32'h0000AABB, 2'b00, 2);

      issue(MEM_SB, 32'h203, 32'h123456C3, 5'd7);
      check_value("sb.op", 32'(mem_request.op), 32'(MEM_SB));
      check_value("sb.data", mem_request.data, 32'hC3C3C3C3);
      @(posedge clk);
      #1;
      check_value("sb.op_one_cycle", 32'(mem_request.op), 32'(MEM_NOP));
      wait_resp(c);
      check_value("sb.latency", 32'(c), 32'd1);
      check_value("sb.data_zero", resp_data, 32'd0);
      check_value("sb.fault", 32'(resp_fault), 32'd0);
      check_value("sb.rd", 32'(resp_rd), 32'd7);
      @(posedge clk);
      #1;
      access("lw200", MEM_LW, 32'h200, 32'd0, 5'd8, 32'hC3000000, 2'b00, 2);

      access("lw102_mis", MEM_LW, 32'h102, 32'd0, 5'd10, 32'd0, 2'b01, 0);
      access("sh001_mis", MEM_SH, 32'h001, 32'hFFFF, 5'd11, 32'd0, 2'b01, 0);

      issue(MEM_NOP, 32'h100, 32'd0, 5'd12);
      check_value("nop.req_ready", 32'(req_ready), 32'd1);
      check_value("nop.resp_valid", 32'(resp_valid), 32'd0);

      mem_en     = 1'b0;
      resp_ready = 1'b0;
      issue(MEM_LW, 32'h100, 32'd0, 5'd9);
      wait_resp(c);
      check_value("to.latency", 32'(c), 32'd5);
      check_value("to.fault", 32'(resp_fault), 32'd2);
      check_value("to.data", resp_data, 32'd0);
      check_value("to.rd", 32'(resp_rd), 32'd9);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_value("to.hold_valid", 32'(resp_valid), 32'd1);
         check_value("to.hold_fault", 32'(resp_fault), 32'd2);
         check_value("to.hold_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_value("to.consumed_valid", 32'(resp_valid), 32'd0);
      check_value("to.consumed_ready", 32'(req_ready), 32'd1);
      check_value("to.consumed_fault", 32'(resp_fault), 32'd0);

      issue(MEM_LW, 32'h100, 32'd0, 5'd13);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check_value("rstw.resp_valid", 32'(resp_valid), 32'd0);
      check_value("rstw.req_ready", 32'(req_ready), 32'd1);
      check_value("rstw.mem_op", 32'(mem_request.op), 32'(MEM_NOP));
      @(posedge clk);
      #1;
      resetn = 1'b1;
      mem_en = 1'b1;
      @(posedge clk);
      #1;
      access("lw_after_rst", MEM_LW, 32'h100, 32'd0, 5'd14, 32'h8899AABB, 2'b00, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
